// File: rtl/uart_boot_loader.sv
// Serial boot loader: receives a framed program image over an 8N1 UART line and
// writes it word-by-word into RAM, holding the core off until the checksum verifies.
//
// state | meaning
// SYNC  | waiting for the 0xA5 sync byte, other bytes dropped
// LEN0  | expecting the length low byte
// LEN1  | expecting the length high byte, range check
// DATA  | assembling little-endian words and writing them to RAM
// CSUM  | expecting the XOR checksum of all data bytes
// DONE  | image accepted, core released (terminal)
// ERR   | protocol, framing, length or checksum failure (terminal)
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_wsize,
    output logic        hold,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      MAX_LEN = 17'(MAX_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        SYNC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    rx_state_t        rx_st;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             frame_err;

    state_t           state;
    logic [7:0]       len_lo;
    logic [15:0]      len;
    logic [15:0]      word_cnt;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_word;
    logic [7:0]       csum;

    // Bit sampler: bit_cnt is a down-counter, each sample taken at terminal count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_st      <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        bit_cnt <= HALF_M1;
                        rx_st   <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rx_s2) begin
                        rx_st <= RX_IDLE;
                    end else begin
                        bit_cnt <= FULL_M1;
                        bit_idx <= '0;
                        rx_st   <= RX_BITS;
                    end
                end
                RX_BITS: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        bit_cnt  <= FULL_M1;
                        if (bit_idx == 3'd7)
                            rx_st <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        rx_st <= RX_IDLE;
                        if (rx_s2)
                            byte_valid <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // rx_shift stays stable from the last data bit until the next byte's first data bit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= SYNC;
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            csum      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wsize <= 2'b00;
            hold      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_wsize <= 2'b00;
            if (mem_wsize == 2'b11)
                mem_addr <= mem_addr + 14'd4;
            case (state)
                SYNC: begin
                    if (byte_valid && rx_shift == 8'hA5)
                        state <= LEN0;
                end
                LEN0: begin
                    if (frame_err) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (byte_valid) begin
                        len_lo <= rx_shift;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (frame_err) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (byte_valid) begin
                        len <= {rx_shift, len_lo};
                        if ({1'b0, rx_shift, len_lo} > MAX_LEN) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if ({rx_shift, len_lo} == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (frame_err) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (byte_valid) begin
                        asm_word <= {rx_shift, asm_word[23:8]};
                        csum     <= csum ^ rx_shift;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {rx_shift, asm_word};
                            mem_wsize <= 2'b11;
                            word_cnt  <= word_cnt + 16'd1;
                            if (word_cnt + 16'd1 == len)
                                state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (frame_err) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (byte_valid) begin
                        if (rx_shift == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                            hold  <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE: state <= DONE;
                ERR:  state <= ERR;
                default: begin
                    state <= ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule
